// File: rtl/axis_frame_packetizer_pkg.sv
// Shared types for the AXI-Stream frame packetizer.
package axis_frame_packetizer_pkg;

   // Frame state: IDLE = no frame open, ACTIVE = frame open.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/axis_frame_packetizer.sv
// AXI-Stream frame packetizer: cuts an input stream into frames of frame_length beats,
// marking the first beat with tuser and the last with tlast, counting completed frames.
// Optional idle-timeout flush is compiled only with AXIS_FRAME_PACKETIZER_TIMEOUT_EN defined;
// in that build non-final beats wait in a one-beat pending register so a late tlast can be forced.
module axis_frame_packetizer
   import axis_frame_packetizer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned COUNTER_WIDTH = 16,
   parameter int unsigned TIMEOUT_WIDTH = 16
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [COUNTER_WIDTH-1:0] frame_length,
`ifdef AXIS_FRAME_PACKETIZER_TIMEOUT_EN
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
`endif
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tuser,
   input  logic                     m_axis_tready,
   output logic [COUNTER_WIDTH-1:0] frame_count,
   output logic                     frame_done
);

   state_e                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] beat_q, beat_d;
   logic [COUNTER_WIDTH-1:0] len_q, len_d;
   logic [COUNTER_WIDTH-1:0] len_cur;
   logic                     out_free;
   logic                     accept;
   logic                     beat_first;
   logic                     beat_last;
   logic                     fire;

   // Output register can take a new beat this cycle.
   assign out_free   = !m_axis_tvalid || m_axis_tready;
   assign accept     = s_axis_tvalid && s_axis_tready;
   // The open frame keeps its latched length; a new frame samples the port.
   assign len_cur    = (state_q == IDLE) ? frame_length : len_q;
   assign beat_first = (beat_q == '0);
   // Length 0 wraps to all-ones here, i.e. 2^COUNTER_WIDTH beats.
   assign beat_last  = (beat_q == len_cur - COUNTER_WIDTH'(1));

`ifdef AXIS_FRAME_PACKETIZER_TIMEOUT_EN
   logic [DATA_WIDTH-1:0]    pend_data;
   logic                     pend_valid;
   logic                     pend_last;
   logic                     pend_user;
   logic [TIMEOUT_WIDTH-1:0] idle_cnt_q;
   logic                     expired;
   logic                     bypass;
   logic                     out_load;

   assign s_axis_tready = !areset && (out_free || !pend_valid);
   assign expired  = pend_valid && !pend_last && (timeout_cycles != '0) && !accept &&
                     (idle_cnt_q + TIMEOUT_WIDTH'(1) == timeout_cycles);
   assign fire     = expired && out_free;
   // A final beat goes straight out only if nothing is queued ahead of it.
   assign bypass   = accept && !pend_valid && beat_last && out_free;
   assign out_load = out_free && (pend_valid ? (accept || pend_last || fire) : bypass);

   // Idle counter: cycles with a pending beat and no input accepted; holds once expired.
   always_ff @(posedge aclk) begin
      if (areset || accept || !pend_valid || fire) begin
         idle_cnt_q <= '0;
      end else if (!expired) begin
         idle_cnt_q <= idle_cnt_q + TIMEOUT_WIDTH'(1);
      end
   end

   // One-beat pending register in front of the output stage.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pend_valid <= 1'b0;
         pend_last  <= 1'b0;
         pend_user  <= 1'b0;
      end else if (accept && !bypass) begin
         pend_valid <= 1'b1;
         pend_data  <= s_axis_tdata;
         pend_last  <= beat_last;
         pend_user  <= beat_first;
      end else if (out_load) begin
         pend_valid <= 1'b0;
      end
   end

   // Output stage fed from pending (tlast forced on timeout) or by bypass.
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (out_free) begin
         m_axis_tvalid <= out_load;
         if (out_load && pend_valid) begin
            m_axis_tdata <= pend_data;
            m_axis_tlast <= pend_last || fire;
            m_axis_tuser <= pend_user;
         end else if (out_load) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= beat_first;
         end
      end
   end
`else
   assign s_axis_tready = !areset && out_free;
   assign fire          = 1'b0;

   // Empty unless the timeout width is nonsensical; keeps the parameter referenced.
   if (TIMEOUT_WIDTH == 0) begin : g_timeout_width_zero
   end

   // Output stage: each accepted beat appears one cycle later.
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (out_free) begin
         m_axis_tvalid <= accept;
         if (accept) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tlast <= beat_last;
            m_axis_tuser <= beat_first;
         end
      end
   end
`endif

   // Frame state, beat index and latched length registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
      end
   end

   // Next-state: open on first beat, close on final beat or forced timeout.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      len_d   = len_q;
      if (accept) begin
         if (state_q == IDLE) begin
            len_d = frame_length;
         end
         if (beat_last) begin
            state_d = IDLE;
            beat_d  = '0;
         end else begin
            state_d = ACTIVE;
            beat_d  = beat_q + COUNTER_WIDTH'(1);
         end
      end else if (fire) begin
         state_d = IDLE;
         beat_d  = '0;
      end
   end

   // Completed-frame counter and pulse on the tlast handshake.
   always_ff @(posedge aclk) begin
      if (areset) begin
         frame_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count <= frame_count + COUNTER_WIDTH'(1);
         end
      end
   end

endmodule
